// File: rtl/board_safety_ctrl.sv
// rtl/board_safety_ctrl.sv - N-axis power/amplifier safety controller
// Owns power enable, relay, per-axis amp disable, host watchdog and motor-voltage settle timer.
module board_safety_ctrl #(
  parameter int NUM_AXES     = 4,
  parameter int TICK_DIV_W   = 8,
  parameter int MV_SETTLE    = 7680,
  parameter int WDOG_PWR_OFF = 0
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                any_wen,
  input  logic                status_wen,
  input  logic [31:0]         status_wdata,
  input  logic                timeout_wen,
  input  logic [15:0]         timeout_wdata,
  input  logic                mv_good,
  input  logic [NUM_AXES-1:0] safety_amp_disable,
  output logic [NUM_AXES-1:0] amp_disable,
  output logic                pwr_enable,
  output logic                relay_on,
  output logic                wdog_timeout,
  output logic [15:0]         wdog_period,
  output logic [NUM_AXES-1:0] axis_fault,
  output logic [31:0]         status_rdata
);

  localparam int MVW = (MV_SETTLE > 1) ? $clog2(MV_SETTLE + 1) : 1;

  typedef enum logic [1:0] {S_OFF, S_SETTLE, S_READY} mv_state_t;

  mv_state_t             mv_state, mv_state_next;
  logic [MVW-1:0]        settle_cnt, settle_cnt_next;
  logic [TICK_DIV_W-1:0] presc;
  logic [15:0]           wdog_count;
  logic [NUM_AXES-1:0]   dis_q, dis_next;
  logic [NUM_AXES-1:0]   wr_mask, amp_cmd, fault_next, amp_en;
  logic                  tick, mv_ready, pwr_cmd, powerup_cmd;
  logic                  wdog_set, wdog_rise;
  logic                  unused_ok;

  assign unused_ok = ^status_wdata;

  assign tick        = &presc;
  assign mv_ready    = (mv_state == S_READY);
  assign wr_mask     = {NUM_AXES{status_wen}} & status_wdata[8 +: NUM_AXES];
  assign amp_cmd     = wr_mask & status_wdata[0 +: NUM_AXES];
  assign pwr_cmd     = status_wen & status_wdata[19] & status_wdata[18];
  assign powerup_cmd = pwr_cmd | (|amp_cmd);

  // A host write always restarts the watchdog, so it can never expire on that cycle.
  assign wdog_set  = ~any_wen & tick & (wdog_period != 16'd0) & (wdog_count == wdog_period);
  assign wdog_rise = wdog_set & ~wdog_timeout & ~powerup_cmd;

  // Enable decisions use the pre-write power state, so power must already be on.
  assign dis_next = (wr_mask & (~{NUM_AXES{pwr_enable}} | ~status_wdata[0 +: NUM_AXES]))
                  | (~wr_mask & dis_q)
                  | safety_amp_disable
                  | {NUM_AXES{~pwr_enable}}
                  | {NUM_AXES{wdog_timeout & ~powerup_cmd}};

  assign fault_next = safety_amp_disable | (axis_fault & ~amp_cmd);

  always_comb begin
    mv_state_next   = mv_state;
    settle_cnt_next = settle_cnt;
    if (!mv_good) begin
      mv_state_next   = S_OFF;
      settle_cnt_next = '0;
    end else begin
      case (mv_state)
        S_OFF: begin
          mv_state_next   = S_SETTLE;
          settle_cnt_next = '0;
        end
        S_SETTLE: begin
          if (tick) begin
            if (settle_cnt == MVW'(MV_SETTLE - 1)) mv_state_next = S_READY;
            else settle_cnt_next = settle_cnt + MVW'(1);
          end
        end
        S_READY: ;
        default: begin
          mv_state_next   = S_OFF;
          settle_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      presc        <= '0;
      wdog_count   <= '0;
      wdog_timeout <= 1'b0;
      wdog_period  <= '0;
      pwr_enable   <= 1'b0;
      relay_on     <= 1'b0;
      dis_q        <= '1;
      amp_disable  <= '1;
      axis_fault   <= '0;
      mv_state     <= S_OFF;
      settle_cnt   <= '0;
    end else begin
      presc      <= presc + TICK_DIV_W'(1);
      mv_state   <= mv_state_next;
      settle_cnt <= settle_cnt_next;

      if (any_wen) wdog_count <= '0;
      else if (tick && wdog_period != 16'd0 && wdog_count < wdog_period)
        wdog_count <= wdog_count + 16'd1;

      if (powerup_cmd) wdog_timeout <= 1'b0;
      else if (wdog_set) wdog_timeout <= 1'b1;

      if (timeout_wen) wdog_period <= timeout_wdata;

      if ((WDOG_PWR_OFF != 0) && wdog_rise) pwr_enable <= 1'b0;
      else if (status_wen && status_wdata[19]) pwr_enable <= status_wdata[18];

      if (status_wen && status_wdata[17]) relay_on <= status_wdata[16];

      dis_q       <= dis_next;
      amp_disable <= dis_q | {NUM_AXES{~mv_ready}};
      axis_fault  <= fault_next;
    end
  end

  assign amp_en       = ~amp_disable;
  assign status_rdata = {8'(NUM_AXES), wdog_timeout, mv_ready, pwr_enable, relay_on, 4'd0,
                         8'(axis_fault), 8'(amp_en)};

endmodule

// File: tb/tb_board_safety_ctrl.sv
// tb/tb_board_safety_ctrl.sv - randomized bench for board_safety_ctrl, two configurations
// Both instances share stimulus and are checked each cycle against a behavioural model.
module tb_board_safety_ctrl;
  localparam int TW  = 2;
  localparam int P   = 4;
  localparam int MVS = 6;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        any_wen = 1'b0, status_wen = 1'b0, timeout_wen = 1'b0, mv_good = 1'b0;
  logic [31:0] status_wdata = '0;
  logic [15:0] timeout_wdata = '0;
  logic [7:0]  safety = '0;

  logic [3:0]  amp0, fault0;
  logic [7:0]  amp1, fault1;
  logic        pwr0, relay0, wdog0, pwr1, relay1, wdog1;
  logic [15:0] period0, period1;
  logic [31:0] rd0, rd1;

  always #5 sysclk = ~sysclk;

  board_safety_ctrl #(.NUM_AXES(4), .TICK_DIV_W(TW), .MV_SETTLE(MVS), .WDOG_PWR_OFF(0)) dut0 (
    .sysclk(sysclk), .reset(reset), .any_wen(any_wen), .status_wen(status_wen),
    .status_wdata(status_wdata), .timeout_wen(timeout_wen), .timeout_wdata(timeout_wdata),
    .mv_good(mv_good), .safety_amp_disable(safety[3:0]), .amp_disable(amp0),
    .pwr_enable(pwr0), .relay_on(relay0), .wdog_timeout(wdog0), .wdog_period(period0),
    .axis_fault(fault0), .status_rdata(rd0));

  board_safety_ctrl #(.NUM_AXES(8), .TICK_DIV_W(TW), .MV_SETTLE(MVS), .WDOG_PWR_OFF(1)) dut1 (
    .sysclk(sysclk), .reset(reset), .any_wen(any_wen), .status_wen(status_wen),
    .status_wdata(status_wdata), .timeout_wen(timeout_wen), .timeout_wdata(timeout_wdata),
    .mv_good(mv_good), .safety_amp_disable(safety), .amp_disable(amp1),
    .pwr_enable(pwr1), .relay_on(relay1), .wdog_timeout(wdog1), .wdog_period(period1),
    .axis_fault(fault1), .status_rdata(rd1));

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Model state, index 0 = 4-axis instance, 1 = 8-axis instance with watchdog power-off
  bit       m_pwr[2], m_relay[2], m_flag[2], m_mvon[2];
  int       m_wcnt[2], m_period[2], m_mvt[2];
  logic [7:0] m_dis[2], m_amp[2], m_fault[2];
  int       m_cyc;

  function automatic int na(input int k);
    return (k == 1) ? 8 : 4;
  endfunction

  function automatic logic [7:0] msk(input int k);
    return (k == 1) ? 8'hFF : 8'h0F;
  endfunction

  function automatic bit ready(input int k);
    return m_mvon[k] && (m_mvt[k] >= MVS);
  endfunction

  function automatic logic [31:0] exp_rd(input int k);
    logic [7:0] en;
    en = ~m_amp[k] & msk(k);
    return {8'(na(k)), m_flag[k], ready(k), m_pwr[k], m_relay[k], 4'd0, m_fault[k], en};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_pwr[k] = 0; m_relay[k] = 0; m_flag[k] = 0; m_mvon[k] = 0;
      m_wcnt[k] = 0; m_period[k] = 0; m_mvt[k] = 0;
      m_dis[k] = msk(k); m_amp[k] = msk(k); m_fault[k] = '0;
    end
    m_cyc = 0;
  endtask

  task automatic model_step();
    bit tick, rdy, pwrc, pu, setc, rise, b, npwr;
    logic [7:0] mk, ampc, nd, nf;
    logic [31:0] d;
    tick = (m_cyc % P) == (P - 1);
    d = status_wdata;
    for (int k = 0; k < 2; k++) begin
      mk   = msk(k);
      rdy  = ready(k);
      pwrc = status_wen && d[19] && d[18];
      ampc = status_wen ? (d[15:8] & d[7:0] & mk) : 8'h00;
      pu   = pwrc || (ampc != 8'h00);
      setc = !any_wen && tick && m_period[k] != 0 && m_wcnt[k] == m_period[k];
      rise = setc && !m_flag[k] && !pu;
      for (int i = 0; i < 8; i++) begin
        b = (status_wen && d[8+i]) ? (!m_pwr[k] || !d[i]) : m_dis[k][i];
        nd[i] = mk[i] && (b || safety[i] || !m_pwr[k] || (m_flag[k] && !pu));
        nf[i] = mk[i] && (safety[i] || (m_fault[k][i] && !ampc[i]));
      end
      m_amp[k] = (m_dis[k] | (rdy ? 8'h00 : 8'hFF)) & mk;
      m_dis[k] = nd;
      m_fault[k] = nf;
      npwr = (status_wen && d[19]) ? d[18] : m_pwr[k];
      if (k == 1 && rise) npwr = 0;
      m_pwr[k] = npwr;
      if (status_wen && d[17]) m_relay[k] = d[16];
      if (any_wen) m_wcnt[k] = 0;
      else if (tick && m_period[k] != 0 && m_wcnt[k] < m_period[k]) m_wcnt[k]++;
      if (pu) m_flag[k] = 0;
      else if (setc) m_flag[k] = 1;
      if (!mv_good) begin m_mvon[k] = 0; m_mvt[k] = 0; end
      else if (!m_mvon[k]) begin m_mvon[k] = 1; m_mvt[k] = 0; end
      else if (tick && m_mvt[k] < MVS) m_mvt[k]++;
      if (timeout_wen) m_period[k] = int'(timeout_wdata);
    end
    m_cyc++;
  endtask

  task automatic compare_all();
    check("rd0", rd0, exp_rd(0));
    check("amp0", {28'd0, amp0}, {24'd0, m_amp[0]});
    check("per0", {16'd0, period0}, m_period[0]);
    check("rd1", rd1, exp_rd(1));
    check("amp1", {24'd0, amp1}, {24'd0, m_amp[1]});
    check("per1", {16'd0, period1}, m_period[1]);
  endtask

  task automatic step();
    @(posedge sysclk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_strobes();
    any_wen = 0; status_wen = 0; timeout_wen = 0;
  endtask

  task automatic wr_status(input logic [31:0] d);
    status_wen = 1; any_wen = 1; status_wdata = d;
    step();
    clear_strobes();
  endtask

  task automatic wr_timeout(input logic [15:0] p);
    timeout_wen = 1; any_wen = 1; timeout_wdata = p;
    step();
    clear_strobes();
  endtask

  // Asserted mid-cycle so the asynchronous path is observed before the next edge.
  task automatic pulse_reset();
    #3;
    reset = 1;
    #1;
    m_reset();
    compare_all();
    @(posedge sysclk);
    #1;
    compare_all();
    reset = 0;
  endtask

  initial begin
    repeat (2) @(posedge sysclk);
    #1;
    reset = 0;
    m_reset();
    compare_all();
    check("rst_rd0", rd0, 32'h0400_0000);

    // Power up, enable axes, settle
    mv_good = 1;
    wr_status(32'h000C_0F0F);
    step();
    check("t1_first_write_dis", {28'd0, amp0}, 32'hF);
    wr_status(32'h0000_0F0F);
    steps(40);
    check("t1_amp", {28'd0, amp0}, 32'h0);
    check("t1_pwr", {31'd0, pwr0}, 32'h1);

    // Watchdog expiry and recovery
    wr_timeout(16'd3);
    steps(22);
    check("t2_flag", {31'd0, wdog0}, 32'h1);
    check("t2_amp", {28'd0, amp0}, 32'hF);
    check("t2_pwr1", {31'd0, pwr1}, 32'h0);
    wr_status(32'h0000_0F0F);
    step();
    check("t2_clear", {31'd0, wdog0}, 32'h0);
    check("t2_amp_re", {28'd0, amp0}, 32'h0);
    wr_timeout(16'd0);
    step();

    // Safety trip on axis 2
    safety = 8'h04;
    step();
    safety = 8'h00;
    step();
    check("t3_amp2", {31'd0, amp0[2]}, 32'h1);
    check("t3_fault2", {31'd0, fault0[2]}, 32'h1);
    steps(3);
    check("t3_fault_hold", {28'd0, fault0}, 32'h4);
    wr_status(32'h0000_0404);
    step();
    check("t3_amp_clr", {28'd0, amp0}, 32'h0);
    check("t3_fault_clr", {28'd0, fault0}, 32'h0);

    // Supply dropout during READY
    mv_good = 0;
    step();
    mv_good = 1;
    step();
    check("t4_amp", {28'd0, amp0}, 32'hF);
    steps(3);
    check("t4_not_ready", {31'd0, rd0[22]}, 32'h0);
    steps(40);
    check("t4_amp_re", {28'd0, amp0}, 32'h0);

    // Randomized traffic with occasional asynchronous reset
    for (int n = 0; n < 1500; n++) begin
      status_wen  = ($urandom % 5) == 0;
      timeout_wen = ($urandom % 40) == 0;
      any_wen     = status_wen || timeout_wen || (($urandom % 8) == 0);
      status_wdata  = $urandom;
      timeout_wdata = 16'($urandom % 6);
      mv_good = ($urandom % 60) != 0;
      safety  = (($urandom % 30) == 0) ? 8'(1 << ($urandom % 8)) : 8'h00;
      step();
      if (n % 400 == 399) begin
        clear_strobes();
        pulse_reset();
      end
    end
    clear_strobes();
    safety  = 0;
    mv_good = 1;

    // 8-axis instance: watchdog removes power
    wr_timeout(16'd0);
    wr_status(32'h000C_FFFF);
    wr_status(32'h000C_FFFF);
    steps(40);
    check("t5_amp1_en", {24'd0, amp1}, 32'h0);
    check("t5_pwr1_on", {31'd0, pwr1}, 32'h1);
    wr_timeout(16'd3);
    steps(22);
    check("t5_pwr1_off", {31'd0, pwr1}, 32'h0);
    check("t5_amp1", {24'd0, amp1}, 32'hFF);
    check("t5_naxes", {24'd0, rd1[31:24]}, 32'h8);
    check("t5_flag1", {31'd0, wdog1}, 32'h1);

    // Reset during SETTLE with axes enabled
    wr_timeout(16'd0);
    mv_good = 0;
    step();
    mv_good = 1;
    wr_status(32'h000C_0F0F);
    wr_status(32'h0000_0F0F);
    steps(3);
    check("t6_pre_pwr", {31'd0, pwr0}, 32'h1);
    pulse_reset();
    check("t6_amp0", {28'd0, amp0}, 32'hF);
    check("t6_amp1", {24'd0, amp1}, 32'hFF);
    check("t6_rd0", rd0, 32'h0400_0000);
    check("t6_rd1", rd1, 32'h0800_0000);
    steps(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
